elm_layer_sequencer: RTL and testbench

// - Sequences one ELM hidden layer of NUM_NEURONS neuron instances.
// - CFG: serialises a weight/bias stream into per-neuron weight loads (layer/neuron number + weightValid) and one-hot bias loads.
// - RUN: broadcasts one NUM_INPUTS-word frame to all neurons, collects every neuron's outvalid/out, drains results serially on a valid/ready port.

---
 rtl/elm_layer_sequencer.sv | 174 +++++++++++++++++
 tb/tb_elm_layer_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elm_layer_sequencer.sv
// elm_layer_sequencer: configures and runs one ELM hidden layer of NUM_NEURONS neurons.
// Optional argmax classifier over drained results when ELM_ARGMAX_EN is defined.
module elm_layer_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int NUM_INPUTS  = 128,
    parameter int NUM_NEURONS = 30,
    parameter int LAYER_NO    = 1,
    parameter int NEURON_BASE = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_start,
    input  logic                             run_start,
    input  logic [DATA_WIDTH-1:0]            cfg_data,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            nrn_input,
    output logic                             nrn_input_valid,
    output logic [DATA_WIDTH-1:0]            nrn_weight,
    output logic                             nrn_weight_valid,
    output logic [DATA_WIDTH-1:0]            nrn_bias,
    output logic [NUM_NEURONS-1:0]           nrn_bias_valid,
    output logic [2*DATA_WIDTH:0]            nrn_layer_num,
    output logic [2*DATA_WIDTH:0]            nrn_neuron_num,
    input  logic [NUM_NEURONS*OUT_WIDTH-1:0] nrn_out,
    input  logic [NUM_NEURONS-1:0]           nrn_outvalid,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
    output logic                             err_timeout
`ifdef ELM_ARGMAX_EN
    ,
    output logic [$clog2(NUM_NEURONS)-1:0]   class_idx,
    output logic                             class_valid
`endif
);
    localparam int IW = $clog2(NUM_INPUTS);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int TW = $clog2(TIMEOUT);
    localparam int CW = 2 * DATA_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, CFG_W, CFG_B, STREAM, WAIT, DRAIN} state_t;
    state_t state, state_n;

    logic [IW-1:0]        wcnt;
    logic [NW-1:0]        n;
    logic [TW-1:0]        tcnt;
    logic [NUM_NEURONS-1:0] done;
    logic [OUT_WIDTH-1:0] cap [NUM_NEURONS];
    logic w_last, n_last, t_last, all_done, go_run, hs;

    assign cfg_ready      = state == CFG_W || state == CFG_B;
    assign in_ready       = state == STREAM;
    assign out_valid      = state == DRAIN;
    assign out_data       = cap[n];
    assign out_last       = out_valid && n_last;
    assign busy           = state != IDLE;
    assign nrn_layer_num  = CW'(LAYER_NO);
    assign nrn_neuron_num = CW'(NEURON_BASE) + CW'(n);

    always_comb begin
        w_last   = wcnt == IW'(NUM_INPUTS - 1);
        n_last   = n == NW'(NUM_NEURONS - 1);
        t_last   = tcnt == TW'(TIMEOUT - 1);
        all_done = &(done | nrn_outvalid);
        go_run   = run_start && !cfg_start;
        hs       = out_valid && out_ready;
        state_n  = state;
        case (state)
            IDLE:    state_n = cfg_start ? CFG_W : (run_start ? STREAM : IDLE);
            CFG_W:   state_n = (cfg_valid && w_last) ? CFG_B : CFG_W;
            CFG_B:   state_n = cfg_valid ? (n_last ? IDLE : CFG_W) : CFG_B;
            STREAM:  state_n = (in_valid && w_last) ? WAIT : STREAM;
            WAIT:    state_n = all_done ? DRAIN : (t_last ? IDLE : WAIT);
            DRAIN:   state_n = (hs && n_last) ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wcnt             <= '0;
            n                <= '0;
            tcnt             <= '0;
            done             <= '0;
            nrn_input        <= '0;
            nrn_input_valid  <= 1'b0;
            nrn_weight       <= '0;
            nrn_weight_valid <= 1'b0;
            nrn_bias         <= '0;
            nrn_bias_valid   <= '0;
            err_timeout      <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) cap[i] <= '0;
        end else begin
            nrn_input_valid  <= 1'b0;
            nrn_weight_valid <= 1'b0;
            nrn_bias_valid   <= '0;
            case (state)
                IDLE: begin
                    wcnt <= '0;
                    n    <= '0;
                    tcnt <= '0;
                    if (go_run) begin
                        done        <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                CFG_W: if (cfg_valid) begin
                    nrn_weight       <= cfg_data;
                    nrn_weight_valid <= 1'b1;
                    wcnt             <= w_last ? '0 : wcnt + IW'(1);
                end
                CFG_B: if (cfg_valid) begin
                    nrn_bias       <= cfg_data;
                    nrn_bias_valid <= NUM_NEURONS'(1) << n;
                    n              <= n_last ? '0 : n + NW'(1);
                end
                STREAM: if (in_valid) begin
                    nrn_input       <= in_data;
                    nrn_input_valid <= 1'b1;
                    wcnt            <= w_last ? '0 : wcnt + IW'(1);
                end
                WAIT: begin
                    tcnt <= t_last ? '0 : tcnt + TW'(1);
                    if (!all_done && t_last) err_timeout <= 1'b1;
                end
                DRAIN: if (hs) n <= n_last ? '0 : n + NW'(1);
                default: ;
            endcase
            // STREAM included so a pulse on the STREAM->WAIT edge is not lost
            if (state == STREAM || state == WAIT)
                for (int i = 0; i < NUM_NEURONS; i++)
                    if (nrn_outvalid[i]) begin
                        done[i] <= 1'b1;
                        cap[i]  <= nrn_out[i*OUT_WIDTH +: OUT_WIDTH];
                    end
        end
    end

`ifdef ELM_ARGMAX_EN
    logic signed [OUT_WIDTH-1:0] mx;
    logic [NW-1:0]               mi;
    logic                        upd;
    assign upd = n == '0 || $signed(out_data) > mx;
    always_ff @(posedge clk) begin
        if (!rst) begin
            mx          <= '0;
            mi          <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= hs && out_last;
            if (state == IDLE && go_run) class_idx <= '0;
            if (hs) begin
                mx <= upd ? $signed(out_data) : mx;
                mi <= upd ? n : mi;
                if (out_last) class_idx <= upd ? n : mi;
            end
        end
    end
`endif
endmodule

// File: tb/tb_elm_layer_sequencer.sv
// tb_elm_layer_sequencer: scoreboard bench; stimulus pushes expected neuron-side and result
// traffic into queues that a negedge monitor pops and compares.
module tb_elm_layer_sequencer;
    localparam int DW = 16, OW = 16, NI = 4, NN = 2;

    logic clk = 0, rst = 0, cfg_start = 0, run_start = 0;
    logic cfg_valid = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] cfg_data = 0, in_data = 0;
    logic cfg_ready, in_ready, nrn_input_valid, nrn_weight_valid;
    logic [DW-1:0] nrn_input, nrn_weight, nrn_bias;
    logic [NN-1:0] nrn_bias_valid;
    logic [2*DW:0] nrn_layer_num, nrn_neuron_num;
    logic [NN*OW-1:0] nrn_out = 0, model_out = 0;
    logic [NN-1:0] nrn_outvalid = 0, fire_mask = 0;
    logic [OW-1:0] out_data;
    logic out_valid, out_last, busy, err_timeout;
`ifdef ELM_ARGMAX_EN
    logic [$clog2(NN)-1:0] class_idx;
    logic class_valid;
    int q_cls[$];
`endif

    int tests = 0, fails = 0;
    logic [DW-1:0] q_w[$], q_b[$], q_in[$];
    int q_wn[$];
    logic [NN-1:0] q_bv[$];
    logic [OW:0] q_out[$];

    elm_layer_sequencer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_INPUTS(NI), .NUM_NEURONS(NN),
                          .LAYER_NO(1), .NEURON_BASE(0), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .run_start(run_start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .nrn_input(nrn_input), .nrn_input_valid(nrn_input_valid),
        .nrn_weight(nrn_weight), .nrn_weight_valid(nrn_weight_valid),
        .nrn_bias(nrn_bias), .nrn_bias_valid(nrn_bias_valid),
        .nrn_layer_num(nrn_layer_num), .nrn_neuron_num(nrn_neuron_num),
        .nrn_out(nrn_out), .nrn_outvalid(nrn_outvalid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout)
`ifdef ELM_ARGMAX_EN
        , .class_idx(class_idx), .class_valid(class_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Neuron model: fires fire_mask 3 cycles after the NI-th broadcast input word.
    initial begin
        int icnt = 0;
        forever begin
            @(negedge clk);
            if (nrn_input_valid) begin
                icnt++;
                if (icnt == NI) begin
                    icnt = 0;
                    repeat (3) @(posedge clk);
                    #1 nrn_out = model_out; nrn_outvalid = fire_mask;
                    @(posedge clk);
                    #1 nrn_outvalid = '0;
                end
            end
        end
    end

    // Monitor
    initial begin
        int run = 0;
        logic pv = 0, pr = 0, plh = 0;
        logic [OW-1:0] pd = 0;
        forever begin
            @(negedge clk);
            if (nrn_weight_valid) begin
                if (q_w.size() == 0) check("weight_unexpected", 1, 0);
                else begin
                    check("weight", nrn_weight, q_w.pop_front());
                    check("neuron_num", nrn_neuron_num, q_wn.pop_front());
                end
            end
            if (|nrn_bias_valid) begin
                if (q_b.size() == 0) check("bias_unexpected", 1, 0);
                else begin
                    check("bias", nrn_bias, q_b.pop_front());
                    check("bias_valid", nrn_bias_valid, q_bv.pop_front());
                end
            end
            if (nrn_input_valid) begin
                run++;
                if (q_in.size() == 0) check("input_unexpected", 1, 0);
                else check("input", nrn_input, q_in.pop_front());
            end else if (run != 0) begin
                check("input_burst", run, NI);
                run = 0;
            end
            if (pv && !pr) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, pd);
            end
            if (out_valid && out_ready) begin
                if (q_out.size() == 0) check("out_unexpected", 1, 0);
                else check("out_last_data", {out_last, out_data}, q_out.pop_front());
            end
`ifdef ELM_ARGMAX_EN
            check("class_valid_timing", class_valid, plh);
            if (class_valid) begin
                if (q_cls.size() == 0) check("class_unexpected", 1, 0);
                else check("class_idx", class_idx, q_cls.pop_front());
            end
`endif
            plh = out_valid && out_ready && out_last;
            pv = out_valid; pr = out_ready; pd = out_data;
        end
    end

    task automatic cfg_word(input logic [DW-1:0] w);
        cfg_data = w; cfg_valid = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cfg_ready) break;
        end
        if (!cfg_ready) check("cfg_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic in_word(input logic [DW-1:0] w);
        in_data = w; in_valid = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int lim);
        int c = 0;
        do begin @(negedge clk); c++; end while (busy && c < lim);
        check("idle_reached", busy, 0);
        @(posedge clk); #1;
    endtask

    // Words base+1..base+10: NI weights then a bias per neuron; gap after the 2nd word.
    task automatic cfg_layer(input logic [DW-1:0] base);
        cfg_start = 1; @(posedge clk); #1 cfg_start = 0;
        for (int k = 1; k <= (NI + 1) * NN; k++) begin
            if (k % (NI + 1) == 0) begin
                q_b.push_back(base + DW'(k));
                q_bv.push_back(NN'(1) << (k / (NI + 1) - 1));
            end else begin
                q_w.push_back(base + DW'(k));
                q_wn.push_back((k - 1) / (NI + 1));
            end
            cfg_word(base + DW'(k));
            if (k == 2) begin
                cfg_valid = 0;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        cfg_valid = 0;
    endtask

    task automatic do_run(input logic [OW-1:0] o0, input logic [OW-1:0] o1,
                          input logic [NN-1:0] mask, input bit expect_out);
        model_out = {o1, o0}; fire_mask = mask;
        run_start = 1; @(posedge clk); #1 run_start = 0;
        check("err_cleared", err_timeout, 0);
        if (expect_out) begin
            q_out.push_back({1'b0, o0});
            q_out.push_back({1'b1, o1});
`ifdef ELM_ARGMAX_EN
            q_cls.push_back(($signed(o1) > $signed(o0)) ? 1 : 0);
`endif
        end
        for (int i = 0; i < NI; i++) begin
            q_in.push_back(DW'(16'h100 + i));
            in_word(DW'(16'h100 + i));
        end
        in_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_layer_num", nrn_layer_num, 1);
        check("rst_neuron_num", nrn_neuron_num, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err_timeout, 0);
        check("rst_weight_valid", nrn_weight_valid, 0);
        @(posedge clk); #1 rst = 1;

        cfg_layer(16'h0000);
        wait_idle(20);

        out_ready = 1;
        do_run(16'h0011, 16'h0022, 2'b11, 1);
        wait_idle(50);
        check("run1_err", err_timeout, 0);

        out_ready = 0;
        do_run(16'h0005, 16'hFFF0, 2'b11, 1);
        c = 0;
        do begin @(negedge clk); c++; end while (!out_valid && c < 50);
        check("drain_reached", out_valid, 1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 out_ready = 1;
        wait_idle(20);

        do_run(16'h0055, 16'h0066, 2'b01, 0);
        c = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            c++;
        end
        check("timeout_wait_cycles", c, 64);
        check("timeout_err", err_timeout, 1);
        check("timeout_busy", busy, 0);
        @(posedge clk); #1;

        do_run(16'h0030, 16'h0030, 2'b11, 1);
        wait_idle(50);

        cfg_start = 1; @(posedge clk); #1 cfg_start = 0;
        q_w.push_back(16'h0021); q_wn.push_back(0);
        q_w.push_back(16'h0022); q_wn.push_back(0);
        cfg_word(16'h0021);
        cfg_word(16'h0022);
        cfg_valid = 0; rst = 0;
        @(posedge clk); #1;
        check("midrst_busy", busy, 0);
        check("midrst_cfg_ready", cfg_ready, 0);
        check("midrst_weight_valid", nrn_weight_valid, 0);
        rst = 1;
        cfg_layer(16'h0030);
        wait_idle(20);

        repeat (3) @(posedge clk);
        check("q_weight_empty", q_w.size(), 0);
        check("q_bias_empty", q_b.size(), 0);
        check("q_input_empty", q_in.size(), 0);
        check("q_out_empty", q_out.size(), 0);
`ifdef ELM_ARGMAX_EN
        check("q_class_empty", q_cls.size(), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
